// File: rtl/multi_cycle_controller_pkg.sv
// Shared encodings for the multi-cycle RV32I control path: FSM states,
// opcodes, ALU op/control codes and datapath select codes.
package riscv_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_ALUWB    = 4'd7,
        S_EXECI    = 4'd8,
        S_JAL      = 4'd9,
        S_BRANCH   = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10,
        ALUOP_RSVD  = 2'b11
    } alu_op_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_RDATA  = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

endpackage

// File: rtl/multi_cycle_controller_if.sv
// Controller <-> datapath bundle. The controller uses the master side,
// the datapath (or a bench standing in for it) the slave side.
interface multi_cycle_controller_if #(parameter int STATE_W = 4);
    logic [6:0]         op;
    logic [2:0]         funct3;
    logic               funct7b5;
    logic               zero;
    logic               mem_ready;
    logic               pc_write;
    logic               adr_src;
    logic               mem_write;
    logic               ir_write;
    logic [1:0]         result_src;
    logic [1:0]         alu_src_a;
    logic [1:0]         alu_src_b;
    logic [1:0]         imm_src;
    logic [2:0]         alu_control;
    logic               reg_write;
    logic               trap;
    logic [STATE_W-1:0] state_dbg;

    modport master (
        input  op, funct3, funct7b5, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, alu_control, reg_write, trap, state_dbg
    );

    modport slave (
        output op, funct3, funct7b5, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, imm_src, alu_control, reg_write, trap, state_dbg
    );
endinterface

// File: rtl/multi_cycle_controller_alu_decoder.sv
// ALU control decoder: maps alu_op and funct fields to an alu_control code.
// Purely combinational so the single-cycle core can reuse it unchanged.
module alu_decoder
    import riscv_ctrl_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 only selects sub for R-type; addi reuses that bit as immediate
                    3'b000:  alu_control = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end
endmodule

// File: rtl/multi_cycle_controller.sv
// Multi-cycle RV32I main control FSM. The state register is the only flop;
// all datapath controls decode combinationally from state and inputs.
module multi_cycle_controller
    import riscv_ctrl_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    multi_cycle_controller_if.master  bus
);
    state_t     state, next_state;
    alu_op_t    alu_op;
    logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_FETCH;
        else     state <= next_state;
    end

    always_comb begin
        next_state    = state;
        pc_write_c    = 1'b0;
        mem_write_c   = 1'b0;
        ir_write_c    = 1'b0;
        reg_write_c   = 1'b0;
        bus.adr_src   = 1'b0;
        bus.result_src = RES_ALUOUT;
        bus.alu_src_a = SRCA_PC;
        bus.alu_src_b = SRCB_RS2;
        bus.trap      = 1'b0;
        alu_op        = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                bus.alu_src_b  = SRCB_FOUR;
                bus.result_src = RES_ALURES;
                ir_write_c     = bus.mem_ready;
                pc_write_c     = bus.mem_ready;
                if (bus.mem_ready) next_state = S_DECODE;
            end
            S_DECODE: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_IMM;
                case (bus.op)
                    OP_LOAD, OP_STORE: next_state = S_MEMADR;
                    OP_RTYPE:          next_state = S_EXECR;
                    OP_ITYPE:          next_state = S_EXECI;
                    OP_JAL:            next_state = S_JAL;
                    OP_BRANCH:         next_state = S_BRANCH;
                    default:           next_state = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                next_state    = bus.op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                bus.adr_src = 1'b1;
                if (bus.mem_ready) next_state = S_MEMWB;
            end
            S_MEMWB: begin
                bus.result_src = RES_RDATA;
                reg_write_c    = 1'b1;
                next_state     = S_FETCH;
            end
            S_MEMWRITE: begin
                bus.adr_src = 1'b1;
                mem_write_c = 1'b1;
                if (bus.mem_ready) next_state = S_FETCH;
            end
            S_EXECR: begin
                bus.alu_src_a = SRCA_RS1;
                alu_op        = ALUOP_FUNCT;
                next_state    = S_ALUWB;
            end
            S_EXECI: begin
                bus.alu_src_a = SRCA_RS1;
                bus.alu_src_b = SRCB_IMM;
                alu_op        = ALUOP_FUNCT;
                next_state    = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write_c = 1'b1;
                next_state  = S_FETCH;
            end
            S_JAL: begin
                bus.alu_src_a = SRCA_OLDPC;
                bus.alu_src_b = SRCB_FOUR;
                pc_write_c    = 1'b1;
                next_state    = S_ALUWB;
            end
            S_BRANCH: begin
                bus.alu_src_a = SRCA_RS1;
                alu_op        = ALUOP_SUB;
                // funct3[0] distinguishes bne from beq; other funct3 fold onto these
                pc_write_c    = bus.zero ^ bus.funct3[0];
                next_state    = S_FETCH;
            end
            S_TRAP: begin
                bus.trap = 1'b1;
            end
            default: next_state = S_FETCH;
        endcase
    end

    // Reset forces state to FETCH, but FETCH enables follow mem_ready, so gate them too
    assign bus.pc_write  = pc_write_c  & ~rst;
    assign bus.mem_write = mem_write_c & ~rst;
    assign bus.ir_write  = ir_write_c  & ~rst;
    assign bus.reg_write = reg_write_c & ~rst;
    assign bus.state_dbg = STATE_W'(state);

    always_comb begin
        case (bus.op)
            OP_STORE:  bus.imm_src = IMM_S;
            OP_BRANCH: bus.imm_src = IMM_B;
            OP_JAL:    bus.imm_src = IMM_J;
            default:   bus.imm_src = IMM_I;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct3      (bus.funct3),
        .funct7b5    (bus.funct7b5),
        .op5         (bus.op[5]),
        .alu_control (bus.alu_control)
    );
endmodule

// File: tb/tb_multi_cycle_controller.sv
// Scoreboard bench for multi_cycle_controller: directed per-cycle vectors push
// hand-written expected state/control words; a negedge monitor pops and compares.
module tb_multi_cycle_controller;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    multi_cycle_controller_if #(.STATE_W(4)) bus();
    multi_cycle_controller #(.STATE_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct {
        string       nm;
        logic [3:0]  st;
        logic [16:0] ctl;
    } exp_t;

    exp_t sbq[$];
    int total = 0;
    int bad   = 0;

    logic [6:0] p_op  = 7'd0;
    logic [2:0] p_f3  = 3'd0;
    logic       p_f7  = 1'b0;
    logic [1:0] p_imm = 2'b00;

    wire [16:0] act = {bus.pc_write, bus.adr_src, bus.mem_write, bus.ir_write,
                       bus.result_src, bus.alu_src_a, bus.alu_src_b, bus.imm_src,
                       bus.alu_control, bus.reg_write, bus.trap};

    // {pcw,adr,mw,irw,rs,sa,sb,imm,ac,rw,trap}; imm is the hand-set value for the current op
    function automatic logic [16:0] c(input logic pcw, input logic adr, input logic mw,
                                      input logic irw, input logic [1:0] rs,
                                      input logic [1:0] sa, input logic [1:0] sb,
                                      input logic [2:0] ac, input logic rw, input logic tr);
        return {pcw, adr, mw, irw, rs, sa, sb, p_imm, ac, rw, tr};
    endfunction

    function automatic logic [16:0] x_fetch(input logic en);
        return c(en, 1'b0, 1'b0, en, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_dec();
        return c(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b01, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_madr();
        return c(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_mrd();
        return c(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_mwb();
        return c(1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    endfunction
    function automatic logic [16:0] x_mwr();
        return c(1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_exr(input logic [2:0] ac);
        return c(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, ac, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_exi(input logic [2:0] ac);
        return c(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b01, ac, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_wb();
        return c(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1, 1'b0);
    endfunction
    function automatic logic [16:0] x_jal();
        return c(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 2'b10, 3'b000, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_br(input logic pcw);
        return c(pcw, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b00, 3'b001, 1'b0, 1'b0);
    endfunction
    function automatic logic [16:0] x_trap();
        return c(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0, 1'b1);
    endfunction

    task automatic instr(input logic [6:0] o, input logic [2:0] f3, input logic f7,
                         input logic [1:0] imm);
        p_op = o; p_f3 = f3; p_f7 = f7; p_imm = imm;
    endtask

    // One cycle: inputs change just after posedge, expectation queued for the negedge monitor
    task automatic step(input string nm, input int r, input int mr, input int z,
                        input int st, input logic [16:0] ctl);
        exp_t e;
        @(posedge clk); #1;
        rst           = (r != 0);
        bus.mem_ready = (mr != 0);
        bus.zero      = (z != 0);
        bus.op        = p_op;
        bus.funct3    = p_f3;
        bus.funct7b5  = p_f7;
        e.nm  = nm;
        e.st  = st[3:0];
        e.ctl = ctl;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            total++;
            if ({bus.state_dbg, act} !== {e.st, e.ctl}) begin
                bad++;
                $display("FAIL %s: got state=%0d ctl=%05h, expected state=%0d ctl=%05h",
                         e.nm, bus.state_dbg, act, e.st, e.ctl);
            end
        end
    end

    initial begin
        bus.op = 7'd0; bus.funct3 = 3'd0; bus.funct7b5 = 1'b0;
        bus.zero = 1'b0; bus.mem_ready = 1'b0;

        instr(7'b0000000, 3'b000, 1'b0, 2'b00);
        step("reset", 1, 0, 0, 0, x_fetch(1'b0));

        // sw interrupted by reset while stalled in MEMWRITE
        instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        step("sw0_fetch",  0, 1, 0, 0, x_fetch(1'b1));
        step("sw0_dec",    0, 0, 0, 1, x_dec());
        step("sw0_madr",   0, 0, 0, 2, x_madr());
        step("sw0_mwr",    0, 0, 0, 5, x_mwr());
        step("rst_mwr1",   1, 0, 0, 0, x_fetch(1'b0));
        step("rst_mwr2",   1, 0, 0, 0, x_fetch(1'b0));
        step("post_rst1",  0, 0, 0, 0, x_fetch(1'b0));
        step("post_rst2",  0, 0, 0, 0, x_fetch(1'b0));

        instr(7'b0000011, 3'b010, 1'b0, 2'b00);
        step("lw_fetch",   0, 1, 0, 0, x_fetch(1'b1));
        step("lw_dec",     0, 1, 0, 1, x_dec());
        step("lw_madr",    0, 1, 0, 2, x_madr());
        step("lw_mrd",     0, 1, 0, 3, x_mrd());
        step("lw_mwb",     0, 1, 0, 4, x_mwb());

        instr(7'b0100011, 3'b010, 1'b0, 2'b01);
        step("sw_fetch",   0, 1, 0, 0, x_fetch(1'b1));
        step("sw_dec",     0, 1, 0, 1, x_dec());
        step("sw_madr",    0, 1, 0, 2, x_madr());
        step("sw_mwr_s1",  0, 0, 0, 5, x_mwr());
        step("sw_mwr_s2",  0, 0, 0, 5, x_mwr());
        step("sw_mwr_done",0, 1, 0, 5, x_mwr());

        instr(7'b0110011, 3'b000, 1'b1, 2'b00);
        step("sub_fetch",  0, 1, 0, 0, x_fetch(1'b1));
        step("sub_dec",    0, 1, 0, 1, x_dec());
        step("sub_exec",   0, 1, 0, 6, x_exr(3'b001));
        step("sub_wb",     0, 1, 0, 7, x_wb());

        instr(7'b0010011, 3'b000, 1'b1, 2'b00);
        step("addi_fetch", 0, 1, 0, 0, x_fetch(1'b1));
        step("addi_dec",   0, 1, 0, 1, x_dec());
        step("addi_exec",  0, 1, 0, 8, x_exi(3'b000));
        step("addi_wb",    0, 1, 0, 7, x_wb());

        instr(7'b0110011, 3'b010, 1'b0, 2'b00);
        step("slt_fetch",  0, 1, 0, 0, x_fetch(1'b1));
        step("slt_dec",    0, 1, 0, 1, x_dec());
        step("slt_exec",   0, 1, 0, 6, x_exr(3'b101));
        step("slt_wb",     0, 1, 0, 7, x_wb());

        instr(7'b0010011, 3'b111, 1'b0, 2'b00);
        step("andi_fetch", 0, 1, 0, 0, x_fetch(1'b1));
        step("andi_dec",   0, 1, 0, 1, x_dec());
        step("andi_exec",  0, 1, 0, 8, x_exi(3'b010));
        step("andi_wb",    0, 1, 0, 7, x_wb());

        instr(7'b0110011, 3'b110, 1'b0, 2'b00);
        step("or_fetch",   0, 1, 0, 0, x_fetch(1'b1));
        step("or_dec",     0, 1, 0, 1, x_dec());
        step("or_exec",    0, 1, 0, 6, x_exr(3'b011));
        step("or_wb",      0, 1, 0, 7, x_wb());

        instr(7'b0110011, 3'b100, 1'b1, 2'b00);
        step("xor_fetch",  0, 1, 0, 0, x_fetch(1'b1));
        step("xor_dec",    0, 1, 0, 1, x_dec());
        step("xor_exec",   0, 1, 0, 6, x_exr(3'b000));
        step("xor_wb",     0, 1, 0, 7, x_wb());

        instr(7'b1101111, 3'b000, 1'b0, 2'b11);
        step("jal_fetch",  0, 1, 0, 0, x_fetch(1'b1));
        step("jal_dec",    0, 1, 0, 1, x_dec());
        step("jal_jal",    0, 1, 0, 9, x_jal());
        step("jal_wb",     0, 1, 0, 7, x_wb());

        instr(7'b1100011, 3'b000, 1'b0, 2'b10);
        step("beq_t_fetch",0, 1, 1, 0, x_fetch(1'b1));
        step("beq_t_dec",  0, 1, 1, 1, x_dec());
        step("beq_t_br",   0, 1, 1, 10, x_br(1'b1));
        step("beq_n_fetch",0, 1, 0, 0, x_fetch(1'b1));
        step("beq_n_dec",  0, 1, 0, 1, x_dec());
        step("beq_n_br",   0, 1, 0, 10, x_br(1'b0));

        instr(7'b1100011, 3'b001, 1'b0, 2'b10);
        step("bne_t_fetch",0, 1, 0, 0, x_fetch(1'b1));
        step("bne_t_dec",  0, 1, 0, 1, x_dec());
        step("bne_t_br",   0, 1, 0, 10, x_br(1'b1));
        step("bne_n_fetch",0, 1, 1, 0, x_fetch(1'b1));
        step("bne_n_dec",  0, 1, 1, 1, x_dec());
        step("bne_n_br",   0, 1, 1, 10, x_br(1'b0));

        instr(7'b1100011, 3'b100, 1'b0, 2'b10);
        step("b100_fetch", 0, 1, 1, 0, x_fetch(1'b1));
        step("b100_dec",   0, 1, 1, 1, x_dec());
        step("b100_br",    0, 1, 1, 10, x_br(1'b1));

        instr(7'b1110011, 3'b000, 1'b0, 2'b00);
        step("ill_fetch",  0, 1, 0, 0, x_fetch(1'b1));
        step("ill_dec",    0, 1, 0, 1, x_dec());
        for (int i = 0; i < 12; i++) step("ill_trap", 0, 1, 1, 11, x_trap());
        step("trap_rst",   1, 1, 0, 0, x_fetch(1'b0));
        step("trap_rel",   0, 1, 0, 0, x_fetch(1'b1));
        step("trap_dec",   0, 1, 0, 1, x_dec());

        for (int i = 0; i < 4 && sbq.size() != 0; i++) @(posedge clk);
        if (sbq.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left, expected 0", sbq.size());
        end
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
